// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IC/DM memory-port arbiter.
// Purely declarative; no timing or flow-control behaviour lives here.
package arvi_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int ARB_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; slave = arbiter view.
// Error strobes exist only when ARVI_ARB_TIMEOUT_EN is defined.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic              i_ic_req;
    logic [XLEN-1:0]   i_ic_addr;
    logic [XLEN-1:0]   o_ic_data;
    logic              o_ic_ready;

    logic              i_dm_req;
    logic              i_dm_we;
    logic [XLEN/8-1:0] i_dm_be;
    logic [XLEN-1:0]   i_dm_addr;
    logic [XLEN-1:0]   i_dm_wdata;
    logic              i_dm_lock;
    logic [XLEN-1:0]   o_dm_rdata;
    logic              o_dm_ready;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [XLEN/8-1:0] o_mem_be;
    logic [XLEN-1:0]   o_mem_addr;
    logic [XLEN-1:0]   o_mem_wdata;
    logic [XLEN-1:0]   i_mem_rdata;
    logic              i_mem_ready;

    logic              o_owner;
`ifdef ARVI_ARB_TIMEOUT_EN
    logic              o_ic_err;
    logic              o_dm_err;
`endif

    modport slave (
        input  i_ic_req, i_ic_addr,
        input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata, i_dm_lock,
        input  i_mem_rdata, i_mem_ready,
        output o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready,
        output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        output o_owner
`ifdef ARVI_ARB_TIMEOUT_EN
        , output o_ic_err, o_dm_err
`endif
    );

    modport master (
        output i_ic_req, i_ic_addr,
        output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata, i_dm_lock,
        output i_mem_rdata, i_mem_ready,
        input  o_ic_data, o_ic_ready, o_dm_rdata, o_dm_ready,
        input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
        input  o_owner
`ifdef ARVI_ARB_TIMEOUT_EN
        , input o_ic_err, o_dm_err
`endif
    );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin choice between IC and DM, honouring the DM lock.
// Zero latency; no backpressure of its own.
module arb_rr_picker
    import arvi_arb_pkg::*;
(
    input  logic ic_req,
    input  logic dm_req,
    input  logic owner,
    input  logic lock,
    output logic grant_valid,
    output logic grant_dm
);

    always_comb begin
        grant_valid = 1'b0;
        grant_dm    = 1'b0;
        if (lock) begin
            grant_valid = dm_req;
            grant_dm    = 1'b1;
        end else if (ic_req && dm_req) begin
            // Tie goes to whoever was not served last.
            grant_valid = 1'b1;
            grant_dm    = (owner == OWN_IC);
        end else begin
            grant_valid = ic_req | dm_req;
            grant_dm    = dm_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IC refill and DM; ready pulses L+2 cycles after request.
// Requesters hold req until ready; memory holds off via i_mem_ready. ARVI_ARB_TIMEOUT_EN adds a watchdog.
module mem_arbiter
    import arvi_arb_pkg::*;
#(
    parameter int XLEN = 32
`ifdef ARVI_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
`endif
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mem_arbiter_if.slave bus
);

    localparam int BEW = XLEN / 8;

    arb_state_e      state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [BEW-1:0]  mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] ic_data_q, ic_data_d;
    logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
    logic            ic_ready_q, ic_ready_d;
    logic            dm_ready_q, dm_ready_d;
    logic            owner_q, owner_d;
    logic            lock_q, lock_d;
    logic            lock_pend_q, lock_pend_d;
    logic            grant_valid;
    logic            grant_dm;

`ifdef ARVI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ic_err_q, ic_err_d;
    logic             dm_err_q, dm_err_d;
`endif

    arb_rr_picker u_picker (
        .ic_req      (bus.i_ic_req),
        .dm_req      (bus.i_dm_req),
        .owner       (owner_q),
        .lock        (lock_q),
        .grant_valid (grant_valid),
        .grant_dm    (grant_dm)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_data_q   <= '0;
            dm_rdata_q  <= '0;
            ic_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            owner_q     <= OWN_DM;
            lock_q      <= 1'b0;
            lock_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ic_data_q   <= ic_data_d;
            dm_rdata_q  <= dm_rdata_d;
            ic_ready_q  <= ic_ready_d;
            dm_ready_q  <= dm_ready_d;
            owner_q     <= owner_d;
            lock_q      <= lock_d;
            lock_pend_q <= lock_pend_d;
        end
    end

`ifdef ARVI_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            ic_err_q <= 1'b0;
            dm_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ic_err_q <= ic_err_d;
            dm_err_q <= dm_err_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ic_data_d   = ic_data_q;
        dm_rdata_d  = dm_rdata_q;
        ic_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        owner_d     = owner_q;
        lock_d      = lock_q;
        lock_pend_d = lock_pend_q;
`ifdef ARVI_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        ic_err_d    = 1'b0;
        dm_err_d    = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    state_d   = ARB_BUSY;
                    mem_req_d = 1'b1;
                    owner_d   = grant_dm;
                    if (grant_dm) begin
                        mem_we_d    = bus.i_dm_we;
                        mem_be_d    = bus.i_dm_be;
                        mem_addr_d  = bus.i_dm_addr;
                        mem_wdata_d = bus.i_dm_wdata;
                        lock_pend_d = bus.i_dm_lock;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_be_d    = '1;
                        mem_addr_d  = bus.i_ic_addr;
                        mem_wdata_d = '0;
                    end
`ifdef ARVI_ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (bus.i_mem_ready) begin
                    state_d   = ARB_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_ready_d = 1'b1;
                        // Writes leave the DM read-data register untouched.
                        if (!mem_we_q) begin
                            dm_rdata_d = bus.i_mem_rdata;
                        end
                    end else begin
                        ic_ready_d = 1'b1;
                        ic_data_d  = bus.i_mem_rdata;
                    end
                end
`ifdef ARVI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    state_d     = ARB_RESP;
                    mem_req_d   = 1'b0;
                    lock_pend_d = 1'b0;
                    lock_d      = 1'b0;
                    if (owner_q == OWN_DM) begin
                        dm_ready_d = 1'b1;
                        dm_err_d   = 1'b1;
                        dm_rdata_d = '0;
                    end else begin
                        ic_ready_d = 1'b1;
                        ic_err_d   = 1'b1;
                        ic_data_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ARB_RESP: begin
                // No grant here so a requester still holding req is not served twice.
                state_d = ARB_IDLE;
                if (owner_q == OWN_DM) begin
                    lock_d = lock_pend_q;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_be    = mem_be_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_ic_data   = ic_data_q;
    assign bus.o_dm_rdata  = dm_rdata_q;
    assign bus.o_ic_ready  = ic_ready_q;
    assign bus.o_dm_ready  = dm_ready_q;
    assign bus.o_owner     = owner_q;
`ifdef ARVI_ARB_TIMEOUT_EN
    assign bus.o_ic_err    = ic_err_q;
    assign bus.o_dm_err    = dm_err_q;
`endif

endmodule
